// File: rtl/ram_port_arbiter_if.sv
// Client-side req/gnt command bus shared by both requesters of ram_port_arbiter.
// Requester i uses bit i of each 2-bit vector and slice i of the packed address/data buses.
`timescale 1ns/1ps
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [1:0]          req;
  logic [1:0]          we_i;
  logic [2*ADDR_W-1:0] addr_i;
  logic [2*DATA_W-1:0] wdata_i;
  logic [1:0]          gnt;
  logic [1:0]          rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, we_i, addr_i, wdata_i,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we_i, addr_i, wdata_i,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer in front of single_port_ram (registered q output).
// Define RAM_ARB_RR_EN for round-robin arbitration; default build is fixed priority (requester 0).
`timescale 1ns/1ps
module ram_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_write_addr,
  output logic [ADDR_W-1:0]   ram_read_addr,
  output logic [DATA_W-1:0]   ram_data,
  input  logic [DATA_W-1:0]   ram_q
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e              state_q;
  logic [1:0]          gnt_q;
  logic [1:0]          rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                owner_q;
`ifdef RAM_ARB_RR_EN
  logic                ptr_q;
`endif

  logic                winner_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_data_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    winner_d = 1'b0;
`ifdef RAM_ARB_RR_EN
    // On a conflict the requester that was not granted last wins.
    if (bus.req == 2'b11) winner_d = ~ptr_q;
    else                  winner_d = ~bus.req[0];
`else
    winner_d = ~bus.req[0];
`endif
    sel_we_d   = winner_d ? bus.we_i[1]                : bus.we_i[0];
    sel_addr_d = winner_d ? bus.addr_i[ADDR_W +: ADDR_W] : bus.addr_i[0 +: ADDR_W];
    sel_data_d = winner_d ? bus.wdata_i[DATA_W +: DATA_W] : bus.wdata_i[0 +: DATA_W];
  end

  // Single-process FSM; gnt, ram_we and the RAM command are all registered on the grant edge
  // so they appear together in the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      ram_we_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      owner_q  <= 1'b0;
`ifdef RAM_ARB_RR_EN
      ptr_q    <= 1'b1;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      gnt_q    <= '0;
      rvalid_q <= '0;
      ram_we_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|bus.req) begin
            gnt_q    <= winner_d ? 2'b10 : 2'b01;
            owner_q  <= winner_d;
            ram_we_q <= sel_we_d;
            addr_q   <= sel_addr_d;
            data_q   <= sel_data_d;
`ifdef RAM_ARB_RR_EN
            ptr_q    <= winner_d;
`endif
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // ram_we_q still holds the command type during ISSUE.
          state_q <= ram_we_q ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          rdata_q  <= ram_q;
          rvalid_q <= owner_q ? 2'b10 : 2'b01;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = rdata_q;
  assign busy           = (state_q != ST_IDLE);
  assign ram_we         = ram_we_q;
  assign ram_write_addr = addr_q;
  assign ram_read_addr  = addr_q;
  assign ram_data       = data_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: a service-order model predicts grant/read events,
// a negedge monitor pops and compares them against what the DUT presents.
`timescale 1ns/1ps
module tb_ram_port_arbiter;
  localparam int AW = 7;
  localparam int DW = 8;
`ifdef RAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic          busy;
  logic          ram_we;
  logic [AW-1:0] ram_write_addr;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .busy           (busy),
    .ram_we         (ram_we),
    .ram_write_addr (ram_write_addr),
    .ram_read_addr  (ram_read_addr),
    .ram_data       (ram_data),
    .ram_q          (ram_q)
  );

  // Behavioural single_port_ram: synchronous write, registered read.
  logic [DW-1:0] ram_mem [1<<AW];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_write_addr] <= ram_data;
    ram_q <= ram_mem[ram_read_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
  } cmd_t;

  typedef struct {
    bit          is_rv;
    bit          id;
    bit          we;
    bit [AW-1:0] addr;
    bit [DW-1:0] data;
  } ev_t;

  cmd_t        c0[$];
  cmd_t        c1[$];
  ev_t         exp_q[$];
  bit [DW-1:0] model_mem [1<<AW];
  bit          model_last = 1'b1;

  // Service order from the arbitration rule applied to the two pending command lists.
  task automatic plan();
    cmd_t a[$];
    cmd_t b[$];
    cmd_t c;
    ev_t  e;
    bit   pick;
    a = c0;
    b = c1;
    while (a.size() != 0 || b.size() != 0) begin
      if (a.size() != 0 && b.size() != 0) pick = RR_EN ? !model_last : 1'b0;
      else                                pick = (a.size() == 0);
      if (pick) c = b.pop_front();
      else      c = a.pop_front();
      model_last = pick;
      e = '{is_rv: 1'b0, id: pick, we: c.we, addr: c.addr, data: c.data};
      exp_q.push_back(e);
      if (c.we) begin
        model_mem[c.addr] = c.data;
      end else begin
        e = '{is_rv: 1'b1, id: pick, we: 1'b0, addr: c.addr, data: model_mem[c.addr]};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic present();
    bus.req[0] = (c0.size() != 0);
    bus.req[1] = (c1.size() != 0);
    if (c0.size() != 0) begin
      bus.we_i[0]          = c0[0].we;
      bus.addr_i[0 +: AW]  = c0[0].addr;
      bus.wdata_i[0 +: DW] = c0[0].data;
    end
    if (c1.size() != 0) begin
      bus.we_i[1]           = c1[0].we;
      bus.addr_i[AW +: AW]  = c1[0].addr;
      bus.wdata_i[DW +: DW] = c1[0].data;
    end
  endtask

  task automatic wait_idle_and_drain();
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("idle_timeout", n < 20, 1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  // Drives both command lists concurrently, holding req until each command is granted.
  task automatic run_round();
    int         budget;
    int         start;
    int         last_g;
    int         gap_exp;
    bit         first;
    logic [1:0] g;
    budget  = 0;
    last_g  = 0;
    gap_exp = 0;
    first   = 1'b1;
    @(posedge clk); #1;
    plan();
    present();
    start = cyc;
    while ((c0.size() != 0 || c1.size() != 0) && budget < 200) begin
      @(negedge clk);
      g = bus.gnt;
      if (g != 2'b00) begin
        if (first) check("gnt_latency", cyc - start, 1);
        else       check("gnt_spacing", cyc - last_g, gap_exp);
        first  = 1'b0;
        last_g = cyc;
        if (g[0] && c0.size() != 0) begin
          gap_exp = c0[0].we ? 2 : 3;
          c0.delete(0);
        end else if (g[1] && c1.size() != 0) begin
          gap_exp = c1[0].we ? 2 : 3;
          c1.delete(0);
        end
      end
      @(posedge clk); #1;
      present();
      budget++;
    end
    check("round_timeout", budget < 200, 1);
    c0.delete();
    c1.delete();
    present();
    wait_idle_and_drain();
  endtask

  function automatic cmd_t mk(input bit we, input int addr, input int data);
    cmd_t c;
    c.we   = we;
    c.addr = addr[AW-1:0];
    c.data = data[DW-1:0];
    return c;
  endfunction

  // Monitor: every grant or read-valid the DUT presents is popped and compared.
  int  rd_cyc = 0;
  ev_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.gnt != 2'b00) begin
        check("gnt_onehot", $countones(bus.gnt), 1);
        if (exp_q.size() == 0) begin
          check("gnt_unexpected", {30'd0, bus.gnt}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("gnt_event_kind", {31'd0, mon_e.is_rv}, 0);
          check("gnt_owner", {30'd0, bus.gnt}, mon_e.id ? 2 : 1);
          check("ram_we", {31'd0, ram_we}, {31'd0, mon_e.we});
          check("ram_write_addr", ram_write_addr, mon_e.addr);
          check("ram_read_addr", ram_read_addr, mon_e.addr);
          if (mon_e.we) check("ram_data", ram_data, mon_e.data);
          else          rd_cyc = cyc;
        end
      end else begin
        check("ram_we_outside_issue", {31'd0, ram_we}, 0);
      end
      if (bus.rvalid != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("rvalid_unexpected", {30'd0, bus.rvalid}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rvalid_event_kind", {31'd0, mon_e.is_rv}, 1);
          check("rvalid_owner", {30'd0, bus.rvalid}, mon_e.id ? 2 : 1);
          check("rdata", bus.rdata, mon_e.data);
          check("rvalid_latency", cyc - rd_cyc, 2);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, {30'd0, bus.gnt}, 0);
    check({tag, "_rvalid"}, {30'd0, bus.rvalid}, 0);
    check({tag, "_rdata"}, bus.rdata, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 0);
    check({tag, "_ram_write_addr"}, ram_write_addr, 0);
    check({tag, "_ram_read_addr"}, ram_read_addr, 0);
    check({tag, "_ram_data"}, ram_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int         n;
    int         seen;
    int         n0;
    int         n1;
    int         addr;
    ev_t        e;

    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i]   = '0;
      model_mem[i] = '0;
    end
    bus.req     = '0;
    bus.we_i    = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");
    model_last = 1'b1;

    // Single-requester write then read
    c0.push_back(mk(1'b1, 10, 8'hAB));
    run_round();
    c0.push_back(mk(1'b0, 10, 0));
    run_round();

    // Address boundary
    c0.push_back(mk(1'b1, 127, 8'hFF));
    c0.push_back(mk(1'b1, 0, 8'h5A));
    c0.push_back(mk(1'b0, 127, 0));
    c0.push_back(mk(1'b0, 0, 0));
    run_round();

    // Conflict after requester 1 was granted last
    c1.push_back(mk(1'b1, 2, 8'h22));
    run_round();
    c0.push_back(mk(1'b1, 1, 8'h11));
    c1.push_back(mk(1'b1, 3, 8'h33));
    run_round();
    c0.push_back(mk(1'b0, 1, 0));
    c0.push_back(mk(1'b0, 2, 0));
    c0.push_back(mk(1'b0, 3, 0));
    run_round();

    // Requester 1 held high across three back-to-back writes from requester 0
    c0.push_back(mk(1'b1, 20, 8'hA0));
    c0.push_back(mk(1'b1, 21, 8'hA1));
    c0.push_back(mk(1'b1, 22, 8'hA2));
    c1.push_back(mk(1'b1, 23, 8'hB3));
    run_round();

    // Reset during WAIT: read is granted but must never return data
    @(posedge clk); #1;
    e = '{is_rv: 1'b0, id: 1'b0, we: 1'b0, addr: 7'd10, data: model_mem[10]};
    exp_q.push_back(e);
    model_last = 1'b0;
    c0.push_back(mk(1'b0, 10, 0));
    present();
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      if (bus.gnt != 2'b00) break;
      n++;
    end
    check("midread_gnt_timeout", n < 10, 1);
    @(posedge clk); #1;
    c0.delete();
    present();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midread_reset");
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rvalid != 2'b00) seen++;
    end
    check("midread_no_rvalid", seen, 0);
    check("midread_idle_after_release", {31'd0, busy}, 0);
    check("midread_scoreboard_empty", exp_q.size(), 0);
    c0.push_back(mk(1'b0, 10, 0));
    run_round();

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 == 0 && n1 == 0) n0 = 1;
      for (int k = 0; k < n0 + n1; k++) begin
        if ($urandom_range(0, 1) == 0) addr = $urandom_range(0, 7);
        else                           addr = $urandom_range(0, 127);
        if (k < n0) c0.push_back(mk($urandom_range(0, 1) == 1, addr, $urandom_range(0, 255)));
        else        c1.push_back(mk($urandom_range(0, 1) == 1, addr, $urandom_range(0, 255)));
      end
      run_round();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the team's single-port RAM (`single_port_ram`: 7-bit write/read addresses, 8-bit data, registered read output `q`). It accepts read/write commands from two independent masters over a req/gnt handshake and grants one master at a time. It drives the RAM's `we`, `write_addr`, `read_addr` and `data` inputs, and returns read data to the granted master with a one-cycle `rvalid` pulse. It sits between the RAM instance and its clients.

## Interface
- `ADDR_W`, default 7: RAM address width.
- `DATA_W`, default 8: RAM data width.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-requester command request; bit i is requester i.
- `we_i`  in  2  per-requester command type: 1 = write, 0 = read.
- `addr_i`  in  2*ADDR_W  per-requester address; requester i uses `[i*ADDR_W +: ADDR_W]`.
- `wdata_i`  in  2*DATA_W  per-requester write data, sliced the same way.
- `gnt`  out  2  one-hot grant pulse; high for exactly one cycle per accepted command.
- `rvalid`  out  2  one-hot, one-cycle read-data-valid pulse to the read's owner.
- `rdata`  out  DATA_W  read data; meaningful only while `rvalid` is nonzero.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `ram_we`  out  1  to RAM `we`.
- `ram_write_addr`  out  ADDR_W  to RAM `write_addr`.
- `ram_read_addr`  out  ADDR_W  to RAM `read_addr`.
- `ram_data`  out  DATA_W  to RAM `data`.
- `ram_q`  in  DATA_W  from RAM `q`. The RAM registers `q` from `read_addr` on the rising edge.

## Operation
- FSM states are IDLE, ISSUE and WAIT.
- **IDLE:**
  - If any `req` bit is high, pick the winner and latch its `we_i`, `addr_i` and `wdata_i` into command registers.
  - Set `gnt[winner]` and go to ISSUE.
  - With no request, stay in IDLE.
- **ISSUE:**
  - `gnt[winner]`=1 for this cycle.
  - `ram_write_addr` and `ram_read_addr` both take the latched address. `ram_data` takes the latched data.
  - If the command is a write, `ram_we`=1 and the next state is IDLE.
  - If the command is a read, `ram_we`=0 and the next state is WAIT.
- **WAIT:** `ram_q` is valid. Capture it into `rdata` and set `rvalid[owner]`, both registered so they appear in the following cycle. Next state is IDLE.
- `req` is ignored outside IDLE.
- A requester drops `req` on the edge ending its `gnt` cycle. A `req` still high in IDLE is treated as a new command.
- Address and data outputs hold their last value outside ISSUE. `ram_we` is 0 outside ISSUE.
- Addresses are not bounds-checked; the full range 0..2^ADDR_W-1 is legal.
- Winner selection uses a last-granted pointer, which resets to 1 so requester 0 wins the first conflict.
- An `rvalid` pulse may coincide with a new IDLE grant decision.

## Timing
- Let cycle N be the IDLE cycle in which `req` is sampled.
- `gnt` and the RAM command are driven in cycle N+1.
- A write is performed by the RAM at the end of N+1.
- A read has `ram_q` valid in N+2, and `rvalid` plus `rdata` are driven in N+3.
- Throughput: one write per 2 cycles, one read per 3 cycles.
- Reset values:
  - `gnt`, `rvalid`, `rdata`, `ram_we`, `ram_write_addr`, `ram_read_addr`, `ram_data` and `busy` are all 0.
  - FSM is in IDLE; the pointer is 1.
- Reset mid-operation:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - A pending read produces no `rvalid`.
  - A write cut in ISSUE before the clock edge is not performed.

## Configuration
- `RAM_ARB_RR_EN` defined: round-robin arbitration. On a simultaneous request, the requester not granted last wins. The pointer updates on every grant.
- `RAM_ARB_RR_EN` undefined: fixed priority, requester 0 always wins a conflict. The pointer register is not built.

## Test plan
1. **Reset:** hold `rst_n`=0 for 3 cycles, then release. Every output must be 0 and `busy` must be 0.
2. **Single-requester write then read:**
   - Requester 0 writes 0xAB to address 10. `gnt[0]` pulses once. In that same cycle `ram_we`=1, `ram_write_addr`=10 and `ram_data`=0xAB.
   - Requester 0 then reads address 10. `rvalid[0]` pulses 2 cycles after `gnt[0]` with `rdata`=0xAB. `rvalid[1]` stays 0.
3. **Conflict, RR enabled:**
   - Requester 1 alone writes 0x22 to address 2.
   - Then both request in the same cycle: requester 0 writes 0x11 to address 1, requester 1 writes 0x33 to address 3.
   - Required: `gnt[0]` first, then `gnt[1]`. Readback returns 0x11, 0x22 and 0x33.
4. **Conflict, macro undefined:** hold `req[1]` high while requester 0 issues 3 back-to-back writes. All 3 grants go to requester 0 before `gnt[1]` is asserted.
5. **Reset mid-read:** pull `rst_n` low in the WAIT state. No `rvalid` pulse occurs. After release the FSM is in IDLE and the next read completes normally.
6. **Address boundary:** write 0xFF to address 127 and 0x5A to address 0, then read both back. Reads return 0xFF and 0x5A respectively, with no aliasing.
